// File: rtl/connection_block_cfg_pkg.sv
// rtl/connection_block_cfg_pkg.sv - sizing functions, select codes and config FSM states
package connection_block_cfg_pkg;

  localparam int SEL_TIE_LOW = 0;
  localparam int SEL_SINGLE0 = 1;

  function automatic int calc_nsrc(input int ws, input int wd, input int wg,
                                   input int clbx, input int clbout);
    return ws + wd + wg + clbx * clbout;
  endfunction

  function automatic int calc_sel_w(input int nsrc);
    return $clog2(nsrc + 1);
  endfunction

  function automatic int calc_side(input int clbin, input int sel_w, input int clbout,
                                   input int clbos, input int clbod);
    return clbin * sel_w + clbout * (clbos + clbod);
  endfunction

  function automatic int calc_cfg_bits(input int side, input int cfg_w);
    return ((2 * side + cfg_w - 1) / cfg_w) * cfg_w;
  endfunction

  typedef enum logic [1:0] {CFG_IDLE, CFG_SHIFT, CFG_COMMIT} cfg_state_t;

endpackage

// File: rtl/connection_block_cfg_side.sv
// rtl/connection_block_cfg_side.sv - one CLB side: input source muxes and output tap enables
module cb_side
  import connection_block_cfg_pkg::*;
#(
  parameter int WS         = 8,
  parameter int WD         = 8,
  parameter int WG         = 3,
  parameter int CLBIN      = 6,
  parameter int CLBOUT     = 1,
  parameter int CLBOS      = 2,
  parameter int CLBOD      = 2,
  parameter int CLBOS_BIAS = 0,
  parameter int CLBOD_BIAS = 0,
  parameter int CLBX       = 1,
  parameter int K_BASE     = 0,
  parameter int NSRC       = calc_nsrc(WS, WD, WG, CLBX, CLBOUT),
  parameter int SEL_W      = calc_sel_w(NSRC),
  parameter int SIDE       = calc_side(CLBIN, SEL_W, CLBOUT, CLBOS, CLBOD)
) (
  input  logic [SIDE-1:0]   cfg,
  input  logic [WS-1:0]     single_in,
  input  logic [WD-1:0]     double_in,
  input  logic [WG-1:0]     global_in,
  input  logic [CLBOUT-1:0] own_output,
  input  logic [CLBOUT-1:0] opp_output,
  output logic [CLBIN-1:0]  clb_input,
  output logic [WS-1:0]     single_en,
  output logic [WS-1:0]     single_val,
  output logic [WD-1:0]     double_en,
  output logic [WD-1:0]     double_val
);

  localparam int TAP_BASE = CLBIN * SEL_W;
  localparam int TAPS     = CLBOS + CLBOD;

  logic [NSRC:0]    src;
  logic [SEL_W-1:0] sel;

  // src[0] stays low so select code 0 ties the input low.
  always_comb begin
    src = '0;
    sel = '0;
    for (int j = 0; j < WS; j++) src[SEL_SINGLE0 + j] = single_in[j];
    for (int j = 0; j < WD; j++) src[SEL_SINGLE0 + WS + j] = double_in[j];
    for (int j = 0; j < WG; j++) src[SEL_SINGLE0 + WS + WD + j] = global_in[j];
    for (int j = 0; j < CLBX * CLBOUT; j++) src[SEL_SINGLE0 + WS + WD + WG + j] = opp_output[j];
    for (int i = 0; i < CLBIN; i++) begin
      sel = cfg[i*SEL_W +: SEL_W];
      clb_input[i] = (int'(sel) <= NSRC) ? src[sel] : 1'b0;
    end
  end

  // Highest k is visited first so the lowest k is the last writer and wins.
  always_comb begin
    int trk;
    trk        = 0;
    single_en  = '0;
    single_val = '0;
    double_en  = '0;
    double_val = '0;
    for (int k = CLBOUT - 1; k >= 0; k--) begin
      for (int e = 0; e < CLBOS; e++) begin
        if (cfg[TAP_BASE + k*TAPS + e]) begin
          trk = ((K_BASE + k) * CLBOS + e + CLBOS_BIAS) % WS;
          single_en[trk]  = 1'b1;
          single_val[trk] = own_output[k];
        end
      end
      for (int e = 0; e < CLBOD; e++) begin
        if (cfg[TAP_BASE + k*TAPS + CLBOS + e]) begin
          trk = ((K_BASE + k) * CLBOD + e + CLBOD_BIAS) % (WD / 2);
          double_en[trk]  = 1'b1;
          double_val[trk] = own_output[k];
        end
      end
    end
  end

endmodule

// File: rtl/connection_block_cfg.sv
// rtl/connection_block_cfg.sv - two-CLB connection block with shift-loaded shadow/active config
module connection_block_cfg
  import connection_block_cfg_pkg::*;
#(
  parameter int WS         = 8,
  parameter int WD         = 8,
  parameter int WG         = 3,
  parameter int CLBIN      = 6,
  parameter int CLBOUT     = 1,
  parameter int CARRY      = 1,
  parameter int CLBOS      = 2,
  parameter int CLBOD      = 2,
  parameter int CLBOS_BIAS = 0,
  parameter int CLBOD_BIAS = 0,
  parameter int CLBX       = 1,
  parameter int CFG_W      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WS-1:0]     single_in,
  input  logic [WD-1:0]     double_in,
  input  logic [WG-1:0]     global_in,
  input  logic [CLBOUT-1:0] clb0_output,
  input  logic [CLBOUT-1:0] clb1_output,
  input  logic [CARRY-1:0]  clb0_cout,
  input  logic [CARRY-1:0]  clb1_cout,
  output logic [CLBIN-1:0]  clb0_input,
  output logic [CLBIN-1:0]  clb1_input,
  output logic [CARRY-1:0]  clb0_cin,
  output logic [CARRY-1:0]  clb1_cin,
  output logic [WS-1:0]     single_out,
  output logic [WS-1:0]     single_oe,
  output logic [WD-1:0]     double_out,
  output logic [WD-1:0]     double_oe,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  input  logic [CFG_W-1:0]  cfg_data,
  output logic              cfg_ready,
  output logic [CFG_W-1:0]  cfg_out,
  output logic              cfg_done,
  output logic              cfg_err
);

  localparam int NSRC     = calc_nsrc(WS, WD, WG, CLBX, CLBOUT);
  localparam int SEL_W    = calc_sel_w(NSRC);
  localparam int SIDE     = calc_side(CLBIN, SEL_W, CLBOUT, CLBOS, CLBOD);
  localparam int CFG_BITS = calc_cfg_bits(SIDE, CFG_W);
  localparam int CNT_W    = $clog2(CFG_BITS + 1);

  cfg_state_t          state, state_next;
  logic [CFG_BITS-1:0] shadow, active;
  logic [CNT_W-1:0]    count;
  logic                shift_en, commit_en, last_beat, shadow_bad;
  logic [WS-1:0]       s0_en, s0_val, s1_en, s1_val;
  logic [WD-1:0]       d0_en, d0_val, d1_en, d1_val;

  assign last_beat = (int'(count) + CFG_W >= CFG_BITS);
  assign cfg_out   = shadow[CFG_BITS-1 -: CFG_W];
  assign clb1_cin  = clb0_cout;
  assign clb0_cin  = clb1_cout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CFG_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    cfg_ready  = 1'b0;
    shift_en   = 1'b0;
    commit_en  = 1'b0;
    case (state)
      CFG_IDLE:   if (cfg_start) state_next = CFG_SHIFT;
      CFG_SHIFT: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          shift_en = 1'b1;
          if (last_beat) state_next = CFG_COMMIT;
        end
      end
      CFG_COMMIT: begin
        commit_en  = 1'b1;
        state_next = CFG_IDLE;
      end
      default:    state_next = CFG_IDLE;
    endcase
  end

  // Any select beyond the last real source is flagged; it still routes as tied low.
  always_comb begin
    shadow_bad = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < CLBIN; i++)
        if (int'(shadow[s*SIDE + i*SEL_W +: SEL_W]) > NSRC) shadow_bad = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow   <= '0;
      active   <= '0;
      count    <= '0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_done <= commit_en;
      if (state == CFG_IDLE && cfg_start) count <= '0;
      if (shift_en) begin
        shadow <= {shadow[CFG_BITS-CFG_W-1:0], cfg_data};
        count  <= count + CNT_W'(CFG_W);
      end
      if (commit_en) begin
        active  <= shadow;
        cfg_err <= shadow_bad;
      end
    end
  end

  cb_side #(
    .WS(WS), .WD(WD), .WG(WG), .CLBIN(CLBIN), .CLBOUT(CLBOUT), .CLBOS(CLBOS), .CLBOD(CLBOD),
    .CLBOS_BIAS(CLBOS_BIAS), .CLBOD_BIAS(CLBOD_BIAS), .CLBX(CLBX), .K_BASE(0)
  ) u_side0 (
    .cfg(active[0 +: SIDE]), .single_in(single_in), .double_in(double_in), .global_in(global_in),
    .own_output(clb0_output), .opp_output(clb1_output), .clb_input(clb0_input),
    .single_en(s0_en), .single_val(s0_val), .double_en(d0_en), .double_val(d0_val)
  );

  cb_side #(
    .WS(WS), .WD(WD), .WG(WG), .CLBIN(CLBIN), .CLBOUT(CLBOUT), .CLBOS(CLBOS), .CLBOD(CLBOD),
    .CLBOS_BIAS(CLBOS_BIAS), .CLBOD_BIAS(CLBOD_BIAS), .CLBX(CLBX), .K_BASE(CLBOUT)
  ) u_side1 (
    .cfg(active[SIDE +: SIDE]), .single_in(single_in), .double_in(double_in), .global_in(global_in),
    .own_output(clb1_output), .opp_output(clb0_output), .clb_input(clb1_input),
    .single_en(s1_en), .single_val(s1_val), .double_en(d1_en), .double_val(d1_val)
  );

  // clb0 holds the lower k values, so it has priority on shared tracks.
  assign single_oe  = s0_en | s1_en;
  assign single_out = s0_val | (s1_val & ~s0_en);
  assign double_oe  = d0_en | d1_en;
  assign double_out = d0_val | (d1_val & ~d0_en);

endmodule

// File: tb/tb_connection_block_cfg.sv
// tb/tb_connection_block_cfg.sv - randomized bench with a behavioural reference model
module tb_connection_block_cfg;

  localparam int NB = 68;
  localparam int SD = 34;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] single_in = '0, double_in = '0;
  logic [2:0] global_in = '0;
  logic [0:0] clb0_output = '0, clb1_output = '0, clb0_cout = '0, clb1_cout = '0;
  logic [5:0] clb0_input, clb1_input;
  logic [0:0] clb0_cin, clb1_cin;
  logic [7:0] single_out, single_oe, double_out, double_oe;
  logic       cfg_start = 1'b0, cfg_valid = 1'b0;
  logic [0:0] cfg_data = '0;
  logic       cfg_ready, cfg_done, cfg_err;
  logic [0:0] cfg_out;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  connection_block_cfg dut (
    .clk(clk), .rst(rst), .single_in(single_in), .double_in(double_in), .global_in(global_in),
    .clb0_output(clb0_output), .clb1_output(clb1_output), .clb0_cout(clb0_cout), .clb1_cout(clb1_cout),
    .clb0_input(clb0_input), .clb1_input(clb1_input), .clb0_cin(clb0_cin), .clb1_cin(clb1_cin),
    .single_out(single_out), .single_oe(single_oe), .double_out(double_out), .double_oe(double_oe),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .cfg_out(cfg_out), .cfg_done(cfg_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every accepted bit since reset is kept; a commit takes the last NB of them.
  logic        m_hist[$];
  int          m_phase = 0;
  int          m_start = 0;
  logic [NB-1:0] m_active = '0;
  logic        m_done = 1'b0, m_err = 1'b0;

  function automatic logic [NB-1:0] window();
    logic [NB-1:0] w = '0;
    for (int p = 0; p < NB; p++)
      if (m_hist.size() - 1 - p >= 0) w[p] = m_hist[m_hist.size() - 1 - p];
    return w;
  endfunction

  function automatic logic has_bad(input logic [NB-1:0] c);
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 6; i++)
        if (int'(c[s*SD + i*5 +: 5]) > 20) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase  <= 0;
      m_active <= '0;
      m_done   <= 1'b0;
      m_err    <= 1'b0;
      m_hist.delete();
    end else begin
      m_done <= (m_phase == 2);
      if (m_phase == 0 && cfg_start) begin
        m_phase <= 1;
        m_start <= m_hist.size();
      end else if (m_phase == 1 && cfg_valid) begin
        m_hist.push_back(cfg_data[0]);
        if (m_hist.size() - m_start == NB) m_phase <= 2;
      end else if (m_phase == 2) begin
        m_active <= window();
        m_err    <= has_bad(window());
        m_phase  <= 0;
      end
    end
  end

  function automatic logic src_val(input int sel, input int side);
    if (sel >= 1 && sel <= 8)   return single_in[sel-1];
    if (sel >= 9 && sel <= 16)  return double_in[sel-9];
    if (sel >= 17 && sel <= 19) return global_in[sel-17];
    if (sel == 20)              return (side == 0) ? clb1_output[0] : clb0_output[0];
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      logic [5:0] ei0, ei1;
      logic [7:0] eso, esoe, edo, edoe;
      logic       hit, ecout;
      for (int i = 0; i < 6; i++) begin
        ei0[i] = src_val(int'(m_active[i*5 +: 5]), 0);
        ei1[i] = src_val(int'(m_active[SD + i*5 +: 5]), 1);
      end
      for (int t = 0; t < 8; t++) begin
        esoe[t] = 1'b0; eso[t] = 1'b0; edoe[t] = 1'b0; edo[t] = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 2; k++)
          for (int e = 0; e < 2; e++)
            if (!hit && m_active[k*SD + 30 + e] && (k*2 + e) % 8 == t) begin
              hit = 1'b1; esoe[t] = 1'b1; eso[t] = (k == 0) ? clb0_output[0] : clb1_output[0];
            end
        hit = 1'b0;
        for (int k = 0; k < 2; k++)
          for (int e = 0; e < 2; e++)
            if (!hit && m_active[k*SD + 32 + e] && (k*2 + e) % 4 == t) begin
              hit = 1'b1; edoe[t] = 1'b1; edo[t] = (k == 0) ? clb0_output[0] : clb1_output[0];
            end
      end
      ecout = (m_hist.size() >= NB) ? m_hist[m_hist.size() - NB] : 1'b0;
      check("clb0_input", 32'(clb0_input), 32'(ei0));
      check("clb1_input", 32'(clb1_input), 32'(ei1));
      check("single_oe", 32'(single_oe), 32'(esoe));
      check("single_out", 32'(single_out), 32'(eso));
      check("double_oe", 32'(double_oe), 32'(edoe));
      check("double_out", 32'(double_out), 32'(edo));
      check("cfg_ready", 32'(cfg_ready), 32'(m_phase == 1));
      check("cfg_done", 32'(cfg_done), 32'(m_done));
      check("cfg_err", 32'(cfg_err), 32'(m_err));
      check("cfg_out", 32'(cfg_out), 32'(ecout));
      check("clb1_cin", 32'(clb1_cin), 32'(clb0_cout));
      check("clb0_cin", 32'(clb0_cin), 32'(clb1_cout));
    end
  end

  task automatic rand_inputs();
    single_in   = 8'($urandom);
    double_in   = 8'($urandom);
    global_in   = 3'($urandom);
    clb0_output = 1'($urandom);
    clb1_output = 1'($urandom);
    clb0_cout   = 1'($urandom);
    clb1_cout   = 1'($urandom);
  endtask

  function automatic logic [NB-1:0] with_sel(input logic [NB-1:0] c, input int s, input int i, input int v);
    c[s*SD + i*5 +: 5] = 5'(v);
    return c;
  endfunction

  // Bits go out MSB first so that bit p lands at shadow[p] after NB shifts.
  task automatic load(input logic [NB-1:0] c, input int pct, input int abort_at, input bit rnd,
                      input bit mid_chk, output int beats, output int done_cycles);
    int  idx, guard;
    bit  acc, stop;
    beats = 0; done_cycles = 0; idx = NB - 1; guard = 0; stop = 1'b0;
    @(posedge clk); #1 cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
    while (idx >= 0 && !stop) begin
      if (guard >= 2000) begin
        checks++; failures++;
        $display("FAIL load_timeout actual=%0d required=%0d", beats, NB);
        stop = 1'b1;
      end else begin
        cfg_valid = ($urandom_range(99) < pct);
        cfg_data  = c[idx];
        if (rnd) begin rand_inputs(); cfg_start = 1'($urandom); end
        @(negedge clk); acc = cfg_valid && cfg_ready;
        @(posedge clk); #1;
        guard++;
        if (acc) begin
          beats++; idx--;
          if (mid_chk && beats == 34) check("active_held_mid_load", 32'(clb0_input[0]), 32'd1);
          if (beats == abort_at) begin rst = 1'b1; stop = 1'b1; end
        end
      end
    end
    cfg_valid = 1'b0; cfg_start = 1'b0;
    if (!rst) begin
      for (int n = 0; n < 5; n++) begin @(negedge clk); if (cfg_done) done_cycles++; end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [NB-1:0] c;
    int beats, dones;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; chk_on = 1'b1;

    @(negedge clk); #1;
    check("reset_clb0_input", 32'(clb0_input), 32'd0);
    check("reset_clb1_input", 32'(clb1_input), 32'd0);
    check("reset_single_oe", 32'(single_oe), 32'd0);
    check("reset_double_oe", 32'(double_oe), 32'd0);
    check("reset_cfg_ready", 32'(cfg_ready), 32'd0);

    @(posedge clk); #1 single_in = 8'h04;
    c = with_sel('0, 0, 0, 3);
    load(c, 100, -1, 1'b0, 1'b0, beats, dones);
    check("load1_beats", 32'(beats), 32'd68);
    check("load1_done_cycles", 32'(dones), 32'd1);
    check("load1_clb0_in0", 32'(clb0_input[0]), 32'd1);
    check("load1_err", 32'(cfg_err), 32'd0);
    single_in = 8'hFB; #1;
    check("load1_clb0_in0_low", 32'(clb0_input[0]), 32'd0);
    single_in = 8'h04;

    load('0, 50, -1, 1'b0, 1'b1, beats, dones);
    check("load2_beats", 32'(beats), 32'd68);
    check("load2_done_cycles", 32'(dones), 32'd1);
    check("load2_clb0_in0", 32'(clb0_input[0]), 32'd0);

    c = '0; c[30] = 1'b1; c[SD + 30] = 1'b1;
    load(c, 100, -1, 1'b0, 1'b0, beats, dones);
    clb0_output = 1'b1; clb1_output = 1'b0; #1;
    check("tap_single_oe", 32'(single_oe), 32'h05);
    check("tap_single_out_a", 32'(single_out), 32'h01);
    check("tap_double_oe", 32'(double_oe), 32'h00);
    clb0_output = 1'b0; clb1_output = 1'b1; #1;
    check("tap_single_out_b", 32'(single_out), 32'h04);

    single_in = 8'hFF; double_in = 8'hFF; global_in = 3'h7; clb0_output = 1'b1;
    c = with_sel(with_sel('0, 1, 2, 31), 1, 0, 1);
    load(c, 100, -1, 1'b0, 1'b0, beats, dones);
    check("bad_sel_clb1_input", 32'(clb1_input), 32'h01);
    check("bad_sel_err", 32'(cfg_err), 32'd1);
    c = with_sel('0, 1, 2, 20);
    load(c, 100, -1, 1'b0, 1'b0, beats, dones);
    check("good_sel_err", 32'(cfg_err), 32'd0);
    check("direct_clb1_input", 32'(clb1_input), 32'h04);

    load(with_sel('0, 0, 1, 9), 100, 30, 1'b0, 1'b0, beats, dones);
    #1;
    check("abort_beats", 32'(beats), 32'd30);
    check("abort_clb1_input", 32'(clb1_input), 32'd0);
    check("abort_single_oe", 32'(single_oe), 32'd0);
    check("abort_cfg_ready", 32'(cfg_ready), 32'd0);
    check("abort_cfg_out", 32'(cfg_out), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    load(with_sel('0, 0, 1, 9), 100, -1, 1'b0, 1'b0, beats, dones);
    check("restart_beats", 32'(beats), 32'd68);
    check("restart_clb0_in1", 32'(clb0_input[1]), 32'(double_in[0]));

    for (int r = 0; r < 10; r++) begin
      c = {4'($urandom), $urandom, $urandom};
      load(c, 30 + 10 * r % 70, -1, 1'b1, 1'b0, beats, dones);
      check("rand_beats", 32'(beats), 32'd68);
      check("rand_done_cycles", 32'(dones), 32'd1);
      repeat (20) begin @(posedge clk); #1 rand_inputs(); cfg_start = 1'b0; end
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
